// File: rtl/gcd_request_driver_if.sv
// Interface between the GCD request driver and its surroundings: the host
// request/response ports and the serial-load GCD engine bus.
interface gcd_request_driver_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_gcd;
    logic             rsp_timeout;
    logic             busy;
    logic             eng_start;
    logic [WIDTH-1:0] eng_data;
    logic             eng_clear;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;

    // Driver side.
    modport master (
        input  req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
        output req_ready, rsp_valid, rsp_gcd, rsp_timeout, busy,
               eng_start, eng_data, eng_clear
    );

    // Host sequencer plus engine side.
    modport slave (
        output req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
        input  req_ready, rsp_valid, rsp_gcd, rsp_timeout, busy,
               eng_start, eng_data, eng_clear
    );
endinterface

// File: rtl/gcd_request_driver.sv
// GCD request driver: accepts operand pairs, loads them serially into the
// GCD engine, waits for the result under a timeout and returns it on a
// valid/ready response port. Zero operands bypass the engine entirely.
module gcd_request_driver #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    gcd_request_driver_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP,
        CLEAR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;
    logic             eng_used;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             eng_start_q;
    logic [WIDTH-1:0] eng_data_q;
    logic             eng_clear_q;

    // Every output is a register that holds the value belonging to the
    // current state, so nothing combinational reaches the ports.
    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_gcd     = result;
    assign bus.rsp_timeout = timeout_q;
    assign bus.busy        = busy_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_data    = eng_data_q;
    assign bus.eng_clear   = eng_clear_q;

    // Job sequencer: state plus the registered outputs of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            b_q         <= '0;
            result      <= '0;
            cnt         <= '0;
            timeout_q   <= 1'b0;
            eng_used    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_data_q  <= '0;
            eng_clear_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        b_q         <= bus.req_b;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.req_a == '0 || bus.req_b == '0) begin
                            result      <= bus.req_a | bus.req_b;
                            timeout_q   <= 1'b0;
                            eng_used    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            // Operand A goes straight onto the bus so it is
                            // presented together with the start strobe.
                            eng_used    <= 1'b1;
                            eng_start_q <= 1'b1;
                            eng_data_q  <= bus.req_a;
                            state       <= LOAD_A;
                        end
                    end
                end

                LOAD_A: begin
                    eng_start_q <= 1'b0;
                    eng_data_q  <= b_q;
                    state       <= LOAD_B;
                end

                LOAD_B: begin
                    eng_data_q <= '0;
                    cnt        <= '0;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (bus.eng_done) begin
                        result      <= bus.eng_result;
                        timeout_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        result      <= '0;
                        timeout_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (eng_used) begin
                            eng_clear_q <= 1'b1;
                            state       <= CLEAR;
                        end else begin
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                CLEAR: begin
                    // Entered from reset with the pulse still low: raise it
                    // for one cycle here before returning to IDLE.
                    if (eng_clear_q) begin
                        eng_clear_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        eng_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_request_driver.sv
// Testbench for gcd_request_driver: table of directed jobs, hand-written
// reset and done/timeout-collision sequences, and randomized jobs checked
// against a reference model of the request/response rules.
module tb_gcd_request_driver;

    localparam int unsigned W       = 16;
    localparam int unsigned TO_MAIN = 16;
    localparam int unsigned TO_ALT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gcd_request_driver_if #(.WIDTH(W)) bus ();
    gcd_request_driver_if #(.WIDTH(W)) bus2 ();

    gcd_request_driver #(.WIDTH(W), .TIMEOUT(TO_MAIN), .CNT_W(11)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    gcd_request_driver #(.WIDTH(W), .TIMEOUT(TO_ALT), .CNT_W(11)) dut_alt (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          delay;   // WAIT cycle on which the engine finishes, 0 = never
        int          stall;   // cycles rsp_ready is held low
        logic [15:0] gcd;
        logic        tmo;
    } vec_t;

    vec_t tbl[11];

    // Engine model state, sampled on the falling edge.
    int          done_delay = 0;
    int          eng_cnt    = 0;
    int          starts     = 0;
    int          clears     = 0;
    int          bad_data   = 0;
    logic        got_a      = 1'b0;
    logic        running    = 1'b0;
    logic [15:0] cap_a      = '0;
    logic [15:0] cap_b      = '0;

    function automatic logic [15:0] gcd_ref(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p;
        logic [15:0] q;
        logic [15:0] t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural serial-load GCD engine: A with start, B on the next cycle,
    // done (sticky) after done_delay WAIT cycles, cleared by eng_clear.
    always @(negedge clk) begin
        if (bus.eng_clear) begin
            clears++;
            bus.eng_done   = 1'b0;
            bus.eng_result = '0;
            running        = 1'b0;
            got_a          = 1'b0;
        end else if (bus.eng_start) begin
            starts++;
            cap_a = bus.eng_data;
            got_a = 1'b1;
        end else if (got_a) begin
            cap_b   = bus.eng_data;
            got_a   = 1'b0;
            running = (done_delay != 0);
            eng_cnt = done_delay;
        end else begin
            if (bus.eng_data != '0) bad_data++;
            if (running) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    running        = 1'b0;
                    bus.eng_done   = 1'b1;
                    bus.eng_result = gcd_ref(cap_a, cap_b);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.req_ready !== 1'b1) chk({name, " req_ready wait"}, 0, 1);
    endtask

    task automatic post_reset_clear(input string name);
        int n;
        n = 0;
        while (bus.eng_clear !== 1'b1 && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " eng_clear pulse"}, bus.eng_clear, 1);
        chk({name, " busy in clear"}, bus.busy, 1);
        @(posedge clk); #1;
        chk({name, " eng_clear one cycle"}, bus.eng_clear, 0);
        chk({name, " req_ready after clear"}, bus.req_ready, 1);
    endtask

    task automatic do_job(input int id, input logic [15:0] a, input logic [15:0] b,
                          input int delay, input int stall,
                          input logic [15:0] eg, input logic et);
        string nm;
        logic  used;
        int    exp_lat;
        int    lat;
        logic  stable;
        logic [15:0] g0;
        logic  t0;
        nm = $sformatf("job%0d(%0d,%0d)", id, a, b);
        used = (a != 0) && (b != 0);
        if (!used) exp_lat = 0;
        else if (delay != 0 && delay <= int'(TO_MAIN)) exp_lat = 2 + delay;
        else exp_lat = 2 + int'(TO_MAIN);

        wait_ready(nm);
        done_delay = delay;
        starts = 0;
        clears = 0;
        bad_data = 0;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " gcd"}, bus.rsp_gcd, eg);
        chk({nm, " timeout"}, bus.rsp_timeout, et);

        stable = 1'b1;
        g0 = bus.rsp_gcd;
        t0 = bus.rsp_timeout;
        repeat (stall) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== g0 || bus.rsp_timeout !== t0 ||
                bus.req_ready !== 1'b0 || bus.busy !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) chk({nm, " stall hold"}, stable, 1);

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({nm, " rsp_valid drop"}, bus.rsp_valid, 0);
        if (used) begin
            chk({nm, " eng_clear"}, bus.eng_clear, 1);
            @(posedge clk); #1;
            chk({nm, " idle after clear"}, {bus.eng_clear, bus.req_ready, bus.busy}, 3'b010);
            chk({nm, " captured A"}, cap_a, a);
            chk({nm, " captured B"}, cap_b, b);
        end else begin
            chk({nm, " idle after bypass"}, {bus.eng_clear, bus.req_ready, bus.busy}, 3'b010);
        end
        chk({nm, " start count"}, starts, used ? 1 : 0);
        chk({nm, " clear count"}, clears, used ? 1 : 0);
        chk({nm, " idle bus data"}, bad_data, 0);
    endtask

    task automatic reset_mid_job();
        logic zero_ok;
        logic resp_seen;
        wait_ready("rstjob");
        done_delay = 0;
        bus.req_a = 16'd35;
        bus.req_b = 16'd49;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("rstjob busy in WAIT", {bus.busy, bus.rsp_valid}, 2'b10);
        rst = 1'b1;
        zero_ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
                bus.eng_start !== 1'b0 || bus.eng_clear !== 1'b0 || bus.eng_data !== '0 ||
                bus.rsp_gcd !== '0 || bus.rsp_timeout !== 1'b0) zero_ok = 1'b0;
        end
        chk("rstjob outputs zero in reset", zero_ok, 1);
        rst = 1'b0;
        post_reset_clear("rstjob");
        resp_seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) resp_seen = 1'b1;
        end
        chk("rstjob no dropped response", resp_seen, 0);
    endtask

    // TIMEOUT=8 instance: done on WAIT cycle 8 must win over the timeout;
    // the second pass leaves done low and must time out on that same cycle.
    task automatic done_vs_timeout();
        logic early;
        for (int k = 0; k < 2; k++) begin
            bus2.req_a = 16'd30;
            bus2.req_b = 16'd45;
            bus2.req_valid = 1'b1;
            @(posedge clk); #1;
            bus2.req_valid = 1'b0;
            chk($sformatf("alt%0d start with A", k), {bus2.eng_start, bus2.eng_data}, {1'b1, 16'd30});
            @(posedge clk); #1;
            chk($sformatf("alt%0d B after A", k), {bus2.eng_start, bus2.eng_data}, {1'b0, 16'd45});
            early = 1'b0;
            repeat (8) begin
                @(posedge clk); #1;
                if (bus2.rsp_valid !== 1'b0) early = 1'b1;
            end
            chk($sformatf("alt%0d no early response", k), early, 0);
            if (k == 0) begin
                bus2.eng_done = 1'b1;
                bus2.eng_result = 16'd15;
            end
            @(posedge clk); #1;
            chk($sformatf("alt%0d rsp_valid", k), bus2.rsp_valid, 1);
            chk($sformatf("alt%0d gcd", k), bus2.rsp_gcd, (k == 0) ? 16'd15 : 16'd0);
            chk($sformatf("alt%0d timeout", k), bus2.rsp_timeout, (k == 0) ? 1'b0 : 1'b1);
            bus2.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus2.rsp_ready = 1'b0;
            chk($sformatf("alt%0d eng_clear", k), bus2.eng_clear, 1);
            bus2.eng_done = 1'b0;
            bus2.eng_result = '0;
            @(posedge clk); #1;
            chk($sformatf("alt%0d idle", k), {bus2.eng_clear, bus2.req_ready}, 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          rd;
        int          rs;
        logic [15:0] eg;
        logic        et;
        int          g;

        tbl[0]  = '{16'd48,  16'd18, 7,  0, 16'd6,  1'b0};
        tbl[1]  = '{16'd0,   16'd7,  0,  0, 16'd7,  1'b0};
        tbl[2]  = '{16'd0,   16'd0,  0,  0, 16'd0,  1'b0};
        tbl[3]  = '{16'd35,  16'd64, 0,  0, 16'd0,  1'b1};
        tbl[4]  = '{16'd60,  16'd40, 5,  5, 16'd20, 1'b0};
        tbl[5]  = '{16'd21,  16'd14, 3,  0, 16'd7,  1'b0};
        tbl[6]  = '{16'd17,  16'd5,  1,  0, 16'd1,  1'b0};
        tbl[7]  = '{16'd100, 16'd75, 4,  0, 16'd25, 1'b0};
        tbl[8]  = '{16'd12,  16'd12, 16, 2, 16'd12, 1'b0};
        tbl[9]  = '{16'd26,  16'd39, 17, 0, 16'd0,  1'b1};
        tbl[10] = '{16'd9,   16'd0,  0,  1, 16'd9,  1'b0};

        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_result = '0;
        bus2.req_valid = 1'b0;
        bus2.req_a = '0;
        bus2.req_b = '0;
        bus2.rsp_ready = 1'b0;
        bus2.eng_done = 1'b0;
        bus2.eng_result = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            {bus.req_ready, bus.rsp_valid, bus.busy, bus.eng_start, bus.eng_clear, bus.rsp_timeout},
            6'b0);
        chk("reset data", {bus.eng_data, bus.rsp_gcd}, 32'd0);
        rst = 1'b0;
        post_reset_clear("post-reset");
        chk("post-reset alt ready", bus2.req_ready, 1);

        for (int i = 0; i < 11; i++) begin
            do_job(i, tbl[i].a, tbl[i].b, tbl[i].delay, tbl[i].stall, tbl[i].gcd, tbl[i].tmo);
        end

        reset_mid_job();
        done_vs_timeout();

        for (int i = 0; i < 40; i++) begin
            g  = $urandom_range(1, 30);
            ra = 16'(g * $urandom_range(0, 60));
            rb = 16'(g * $urandom_range(0, 60));
            rd = $urandom_range(0, 18);
            rs = $urandom_range(0, 3);
            if (ra == 0 || rb == 0) begin
                eg = ra | rb;
                et = 1'b0;
            end else if (rd != 0 && rd <= int'(TO_MAIN)) begin
                eg = gcd_ref(ra, rb);
                et = 1'b0;
            end else begin
                eg = '0;
                et = 1'b1;
            end
            do_job(100 + i, ra, rb, rd, rs, eg, et);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
